// File: rtl/time_counter.sv
// Stopwatch/watch time base: divides clk down to a centisecond tick and keeps a
// cascaded hh:mm:ss.cc count with run/clear control and per-field calibration.
module time_counter #(
    parameter int DIV_TICK  = 1_000_000,
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic       calib_en,
    input  logic [1:0] calib_sel,
    input  logic       calib_up,
    input  logic       calib_down,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       day_wrap
);

    localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [TW-1:0] TICK_MAX   = TW'(DIV_TICK - 1);
    localparam logic [6:0]    MSEC_MAX   = 7'd99;
    localparam logic [5:0]    SEC_MAX    = 6'd59;
    localparam logic [5:0]    MIN_MAX    = 6'd59;
    localparam logic [4:0]    HOUR_MAX   = 5'd23;
    localparam logic [5:0]    MIN_INIT   = 6'(INIT_MIN);
    localparam logic [4:0]    HOUR_INIT  = 5'(INIT_HOUR);

    localparam logic [1:0] SEL_SEC  = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;

    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [6:0]    msec_reg, msec_next;
    logic [5:0]    sec_reg, sec_next;
    logic [5:0]    min_reg, min_next;
    logic [4:0]    hour_reg, hour_next;
    logic          day_wrap_reg, day_wrap_next;

    logic calib_step;
    assign calib_step = calib_up ^ calib_down;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_reg <= '0;
            msec_reg     <= '0;
            sec_reg      <= '0;
            min_reg      <= MIN_INIT;
            hour_reg     <= HOUR_INIT;
            day_wrap_reg <= 1'b0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
            msec_reg     <= msec_next;
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            day_wrap_reg <= day_wrap_next;
        end
    end

    always_comb begin
        tick_cnt_next = tick_cnt_reg;
        msec_next     = msec_reg;
        sec_next      = sec_reg;
        min_next      = min_reg;
        hour_next     = hour_reg;
        day_wrap_next = 1'b0;

        if (clear) begin
            tick_cnt_next = '0;
            msec_next     = '0;
            sec_next      = '0;
            min_next      = MIN_INIT;
            hour_next     = HOUR_INIT;
        end else if (calib_en) begin
            // Calibration touches one field only; no carry or borrow across fields.
            if (calib_step) begin
                case (calib_sel)
                    SEL_SEC: begin
                        if (calib_up) sec_next = (sec_reg == SEC_MAX) ? 6'd0 : sec_reg + 6'd1;
                        else          sec_next = (sec_reg == 6'd0) ? SEC_MAX : sec_reg - 6'd1;
                    end
                    SEL_MIN: begin
                        if (calib_up) min_next = (min_reg == MIN_MAX) ? 6'd0 : min_reg + 6'd1;
                        else          min_next = (min_reg == 6'd0) ? MIN_MAX : min_reg - 6'd1;
                    end
                    SEL_HOUR: begin
                        if (calib_up) hour_next = (hour_reg == HOUR_MAX) ? 5'd0 : hour_reg + 5'd1;
                        else          hour_next = (hour_reg == 5'd0) ? HOUR_MAX : hour_reg - 5'd1;
                    end
                    default: ;
                endcase
            end
        end else if (run) begin
            if (tick_cnt_reg == TICK_MAX) begin
                tick_cnt_next = '0;
                // Full cascade resolves in this same edge.
                if (msec_reg == MSEC_MAX) begin
                    msec_next = '0;
                    if (sec_reg == SEC_MAX) begin
                        sec_next = '0;
                        if (min_reg == MIN_MAX) begin
                            min_next = '0;
                            if (hour_reg == HOUR_MAX) begin
                                hour_next     = '0;
                                day_wrap_next = 1'b1;
                            end else begin
                                hour_next = hour_reg + 5'd1;
                            end
                        end else begin
                            min_next = min_reg + 6'd1;
                        end
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end else begin
                    msec_next = msec_reg + 7'd1;
                end
            end else begin
                tick_cnt_next = tick_cnt_reg + TW'(1);
            end
        end
    end

    assign msec     = msec_reg;
    assign sec      = sec_reg;
    assign min      = min_reg;
    assign hour     = hour_reg;
    assign day_wrap = day_wrap_reg;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with DIV_TICK=4, INIT_HOUR=12, INIT_MIN=0.
module tb_time_counter;

    logic       clk;
    logic       rst;
    logic       run;
    logic       clear;
    logic       calib_en;
    logic [1:0] calib_sel;
    logic       calib_up;
    logic       calib_down;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       day_wrap;

    int total_checks;
    int passed_checks;

    time_counter #(
        .DIV_TICK (4),
        .INIT_HOUR(12),
        .INIT_MIN (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .calib_en  (calib_en),
        .calib_sel (calib_sel),
        .calib_up  (calib_up),
        .calib_down(calib_down),
        .msec      (msec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day_wrap  (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int cs);
        chk({tag, ".hour"}, 32'(hour), 32'(h));
        chk({tag, ".min"},  32'(min),  32'(m));
        chk({tag, ".sec"},  32'(sec),  32'(s));
        chk({tag, ".msec"}, 32'(msec), 32'(cs));
    endtask

    task automatic pulse_up();
        calib_up = 1'b1;
        step(1);
        calib_up = 1'b0;
    endtask

    task automatic pulse_down();
        calib_down = 1'b1;
        step(1);
        calib_down = 1'b0;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst        = 1'b0;
        run        = 1'b0;
        clear      = 1'b0;
        calib_en   = 1'b0;
        calib_sel  = 2'b11;
        calib_up   = 1'b0;
        calib_down = 1'b0;

        // Reset state
        step(1);
        chk_time("reset", 12, 0, 0, 0);
        chk("reset.day_wrap", 32'(day_wrap), 32'd0);
        rst = 1'b1;

        // First step lands on the 4th edge; 400 edges gives one second
        run = 1'b1;
        step(3);
        chk("t1.edge3.msec", 32'(msec), 32'd0);
        step(1);
        chk("t1.edge4.msec", 32'(msec), 32'd1);
        step(396);
        chk_time("t1.400clk", 12, 0, 1, 0);

        // Pause keeps the partial tick
        step(2);
        run = 1'b0;
        step(10);
        chk("t3.paused.msec", 32'(msec), 32'd0);
        run = 1'b1;
        step(1);
        chk("t3.resume1.msec", 32'(msec), 32'd0);
        step(1);
        chk("t3.resume2.msec", 32'(msec), 32'd1);

        // Reach msec=99, then calibrate to 12:59:59.99
        step(392);
        run = 1'b0;
        chk_time("t2.pre", 12, 0, 1, 99);
        calib_en  = 1'b1;
        calib_sel = 2'b00;
        pulse_down();
        pulse_down();
        calib_sel = 2'b01;
        pulse_down();
        chk_time("t2.preload", 12, 59, 59, 99);
        calib_en = 1'b0;
        run      = 1'b1;
        step(3);
        chk_time("t2.hold", 12, 59, 59, 99);
        step(1);
        chk_time("t2.hour_carry", 13, 0, 0, 0);
        chk("t2.no_day_wrap", 32'(day_wrap), 32'd0);

        // Day rollover
        step(396);
        run = 1'b0;
        calib_en  = 1'b1;
        calib_sel = 2'b10;
        for (int i = 0; i < 10; i++) pulse_up();
        calib_sel = 2'b01;
        pulse_down();
        calib_sel = 2'b00;
        pulse_down();
        chk_time("t2.preload_day", 23, 59, 59, 99);
        calib_en = 1'b0;
        run      = 1'b1;
        step(4);
        chk_time("t2.day_roll", 0, 0, 0, 0);
        chk("t2.day_wrap_hi", 32'(day_wrap), 32'd1);
        step(1);
        chk("t2.day_wrap_lo", 32'(day_wrap), 32'd0);
        run = 1'b0;

        // Calibration: wrap, no carry, run frozen, no-op cases (tick held at 1)
        calib_en  = 1'b1;
        calib_sel = 2'b00;
        run       = 1'b1;
        pulse_down();
        step(7);
        chk_time("t4.frozen_sec59", 0, 0, 59, 0);
        pulse_up();
        chk_time("t4.sec_wrap_up", 0, 0, 0, 0);
        calib_sel = 2'b10;
        pulse_down();
        chk("t4.hour_wrap_down", 32'(hour), 32'd23);
        calib_up   = 1'b1;
        calib_down = 1'b1;
        step(1);
        calib_up   = 1'b0;
        calib_down = 1'b0;
        chk("t4.up_and_down", 32'(hour), 32'd23);
        calib_sel = 2'b11;
        pulse_up();
        chk_time("t4.sel_none", 23, 0, 0, 0);
        calib_en  = 1'b0;
        run       = 1'b0;
        calib_sel = 2'b10;
        pulse_up();
        chk("t4.pulse_no_calib", 32'(hour), 32'd23);
        run = 1'b1;
        step(2);
        chk("t4.resume.msec0", 32'(msec), 32'd0);
        step(1);
        chk("t4.resume.msec1", 32'(msec), 32'd1);

        // Clear wins over calibration and a pending tick
        step(3);
        clear     = 1'b1;
        calib_en  = 1'b1;
        calib_up  = 1'b1;
        step(1);
        clear    = 1'b0;
        calib_en = 1'b0;
        calib_up = 1'b0;
        chk_time("t5.clear", 12, 0, 0, 0);
        step(3);
        chk("t5.tick0.msec0", 32'(msec), 32'd0);
        step(1);
        chk("t5.tick0.msec1", 32'(msec), 32'd1);

        // Asynchronous reset between edges
        step(6);
        chk("t6.pre.msec", 32'(msec), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_time("t6.async", 12, 0, 0, 0);
        #2;
        rst = 1'b1;
        step(3);
        chk("t6.restart.msec0", 32'(msec), 32'd0);
        step(1);
        chk("t6.restart.msec1", 32'(msec), 32'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
